huff_tree_gen: RTL and testbench
================================

Name: huff_tree_gen

Overview:
- Canonical Huffman code-table builder (RFC 1951 §3.2.2 algorithm), upstream of the Huffman decoder.
- On a start pulse it reads tree_num code lengths from an external length buffer, counts them, computes the first code per length, and writes one {code, length} entry per symbol into an external code table at address = symbol index.
- Pulses finish when the table is complete.

Parameters:
- HUFF_CODE_LEN, 8: width of huff_addr (table depth 2^HUFF_CODE_LEN); must be >= 6.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- inc  in  1  start pulse; sampled only in IDLE
- tree_num  in  6  number of symbols (0..63); sampled with inc
- buff_data  in  5  code length read from buffer; valid the cycle after buff_addr is driven
- buff_addr_bias  in  6  base offset into length buffer; sampled with inc
- buff_addr  out  9  length-buffer read address = bias + index, zero-extended
- huff_code  out  5  canonical code, right-aligned, MSB-first bit order
- huff_addr  out  HUFF_CODE_LEN  table write address = symbol index, zero-extended
- huff_len  out  4  code length written (0 = unused symbol)
- winc  out  1  table write enable, one entry per cycle
- finish  out  1  one-cycle done pulse

Behaviour:
- Reset: all outputs 0, state IDLE, bl_count/next_code/index registers cleared. Reset mid-operation aborts immediately; no further writes.
- Outputs are driven from registers only; buff_addr may be combinational from registered bias and index.
- Length range:
  - Supported lengths are 0..5 (CODE_W = 5).
  - buff_data > 5 is treated as 0: not counted, written with len 0.
- FSM:
  - IDLE: on inc=1, latch tree_num and bias, clear bl_count[1..5] and index.
    - Go to COUNT, or to DONE if tree_num = 0.
  - COUNT: drive buff_addr = bias + index, index++ each cycle for tree_num cycles. One cycle later, bl_count[buff_data]++ (length 0 ignored). Lasts tree_num+1 cycles (the last cycle drains).
  - CALC, 1 cycle: code = 0; for b = 1..5: code = (code + bl_count[b-1]) << 1, next_code[b] = code, with bl_count[0] = 0. Arithmetic is modulo 2^5. Reset index.
  - ASSIGN: re-read lengths the same way. One cycle after each address, assert winc with:
    - huff_addr = symbol index, huff_len = len;
    - huff_code = next_code[len] if len != 0, else 0;
    - then next_code[len]++.
    - Writes are consecutive, tree_num cycles, symbol order ascending.
  - DONE: finish = 1 for one cycle, then IDLE.
- inc while not in IDLE is ignored.
- winc is 0 outside ASSIGN write cycles; huff_* hold their last values when winc = 0.
- Oversubscribed length sets are not checked in the base build; codes wrap modulo 2^len.
- Latency from inc to finish = 2*tree_num + 4 cycles for tree_num > 0; 1 cycle for tree_num = 0.

Optional Feature:
- Macro HUFFTREE_OVERSUB_CHK_EN.
- When defined, the block adds output port oversub (1 bit):
  - In CALC, compute Kraft remainder left = 1; for b = 1..5: left = 2*left - bl_count[b].
  - If left goes negative at any step, latch oversub = 1.
  - oversub is held until the next inc or reset and is valid when finish is 1; table writes proceed unchanged.
- When undefined, the port and its logic are absent.

Decomposition:
- Package huff_pkg:
  - CODE_W = 5, LEN_W = 4, MAX_LEN = 5, SYM_W = 6;
  - state enum {IDLE, COUNT, CALC, ASSIGN, DONE};
  - typedefs for code and length.
- One sub-module, huff_next_code_calc: combinational bl_count[1..5] -> next_code[1..5], plus the Kraft check under the macro.

Test Plan:
- Lengths [3,3,3,4,3,2,0,4,0,3], bias 0, tree_num 10, 1-cycle-latency buffer:
  - writes (addr:code/len) 0:2/3, 1:3/3, 2:4/3, 3:14/4, 4:5/3, 5:0/2, 6:0/0, 7:15/4, 8:0/0, 9:6/3;
  - finish 24 cycles after inc.
- Same data placed at buffer offset 20, bias 20 -> buff_addr sweeps 20..29 twice; identical table.
- tree_num 0 -> no winc, finish one cycle after inc.
- inc pulsed again during ASSIGN -> ignored; exactly 10 writes, one finish.
- rst_n low during COUNT -> outputs 0 immediately, no writes; a fresh inc afterward produces a correct table.
- Lengths [1,1,1] with HUFFTREE_OVERSUB_CHK_EN -> oversub=1 at finish; lengths [1,2,2] -> oversub=0 and codes 0/1, 2/2, 3/2.

Source files
------------

// File: rtl/huff_pkg.sv
// Shared types and constants for the canonical Huffman code-table builder.
// Optional feature macro: HUFFTREE_OVERSUB_CHK_EN (Kraft oversubscription flag).
package huff_pkg;

  localparam int CODE_W  = 5;
  localparam int LEN_W   = 4;
  localparam int MAX_LEN = 5;
  localparam int SYM_W   = 6;

  typedef enum logic [2:0] {IDLE, COUNT, CALC, ASSIGN, DONE} state_t;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [LEN_W-1:0]  len_t;

endpackage

// File: rtl/huff_next_code_calc.sv
// Combinational first-code-per-length calculation from the length histogram.
// With HUFFTREE_OVERSUB_CHK_EN defined it also flags length sets whose
// Kraft sum exceeds one (more codes requested than the code space holds).
module huff_next_code_calc
  import huff_pkg::*;
(
  input  logic [MAX_LEN:1][SYM_W-1:0]  bl_count,
  output logic [MAX_LEN:1][CODE_W-1:0] next_code
`ifdef HUFFTREE_OVERSUB_CHK_EN
  ,
  output logic                         oversub
`endif
);

  code_t            code;
  code_t            sum;
  logic [SYM_W-1:0] prev;

  // Walk lengths 1..MAX_LEN, shifting the running code; wraps modulo 2^CODE_W.
  always_comb begin
    code      = '0;
    sum       = '0;
    prev      = '0;
    next_code = '0;
    for (int b = 1; b <= MAX_LEN; b++) begin
      sum          = code + prev[CODE_W-1:0];
      code         = {sum[CODE_W-2:0], 1'b0};
      next_code[b] = code;
      prev         = bl_count[b];
    end
  end

`ifdef HUFFTREE_OVERSUB_CHK_EN
  logic signed [12:0] left;
  logic               over;

  // Remaining code space per length; any negative step means oversubscribed.
  always_comb begin
    left = 13'sd1;
    over = 1'b0;
    for (int b = 1; b <= MAX_LEN; b++) begin
      left = (left <<< 1) - $signed({7'b0, bl_count[b]});
      if (left < 0) over = 1'b1;
    end
  end

  assign oversub = over;
`endif

endmodule

// File: rtl/huff_tree_gen.sv
// Canonical Huffman code-table builder: counts code lengths from an external
// buffer, derives first codes per length, then writes {code, length} per symbol.
// Optional feature macro: HUFFTREE_OVERSUB_CHK_EN adds the oversub output.
module huff_tree_gen
  import huff_pkg::*;
#(
  parameter int HUFF_CODE_LEN = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inc,
  input  logic [5:0]               tree_num,
  input  logic [4:0]               buff_data,
  input  logic [5:0]               buff_addr_bias,
  output logic [8:0]               buff_addr,
  output logic [4:0]               huff_code,
  output logic [HUFF_CODE_LEN-1:0] huff_addr,
  output logic [3:0]               huff_len,
  output logic                     winc,
  output logic                     finish
`ifdef HUFFTREE_OVERSUB_CHK_EN
  ,
  output logic                     oversub
`endif
);

  state_t                       state, state_nx;
  logic [SYM_W-1:0]             tree_q;
  logic [SYM_W-1:0]             bias_q;
  logic [SYM_W-1:0]             index;
  logic [SYM_W-1:0]             sym_idx;
  logic                         rd_pend;
  logic                         idx_last;
  logic [MAX_LEN:1][SYM_W-1:0]  bl_count;
  logic [MAX_LEN:1][CODE_W-1:0] next_code;
  logic [MAX_LEN:1][CODE_W-1:0] calc_code;
  len_t                         len_eff;
  code_t                        sel_code;
`ifdef HUFFTREE_OVERSUB_CHK_EN
  logic                         calc_over;
`endif

  huff_next_code_calc u_calc (
    .bl_count  (bl_count),
    .next_code (calc_code)
`ifdef HUFFTREE_OVERSUB_CHK_EN
    ,
    .oversub   (calc_over)
`endif
  );

  assign idx_last  = (index == tree_q);
  assign sym_idx   = index - SYM_W'(1);
  assign buff_addr = {3'b000, bias_q} + {3'b000, index};

  // Clamp unsupported lengths to zero and pick the masked next code for this length.
  always_comb begin
    len_eff  = (buff_data > 5'(MAX_LEN)) ? '0 : len_t'(buff_data);
    sel_code = '0;
    for (int b = 1; b <= MAX_LEN; b++) begin
      if (len_eff == len_t'(b)) sel_code = next_code[b] & code_t'((1 << b) - 1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; each read pass ends on the drain cycle where index == tree_num.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (inc) state_nx = (tree_num == '0) ? DONE : COUNT;
      COUNT:   if (idx_last) state_nx = CALC;
      CALC:    state_nx = ASSIGN;
      ASSIGN:  if (idx_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: read sweeps, histogram, code load, table writes and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tree_q    <= '0;
      bias_q    <= '0;
      index     <= '0;
      rd_pend   <= 1'b0;
      bl_count  <= '0;
      next_code <= '0;
      huff_code <= '0;
      huff_addr <= '0;
      huff_len  <= '0;
      winc      <= 1'b0;
      finish    <= 1'b0;
`ifdef HUFFTREE_OVERSUB_CHK_EN
      oversub   <= 1'b0;
`endif
    end else begin
      winc   <= 1'b0;
      finish <= (state == DONE);
      case (state)
        IDLE: begin
          if (inc) begin
            tree_q   <= tree_num;
            bias_q   <= buff_addr_bias;
            bl_count <= '0;
            index    <= '0;
            rd_pend  <= 1'b0;
`ifdef HUFFTREE_OVERSUB_CHK_EN
            oversub  <= 1'b0;
`endif
          end
        end
        COUNT, ASSIGN: begin
          if (!idx_last) begin
            index   <= index + SYM_W'(1);
            rd_pend <= 1'b1;
          end else begin
            rd_pend <= 1'b0;
          end
          if (rd_pend && state == COUNT) begin
            for (int b = 1; b <= MAX_LEN; b++) begin
              if (len_eff == len_t'(b)) bl_count[b] <= bl_count[b] + SYM_W'(1);
            end
          end
          if (rd_pend && state == ASSIGN) begin
            winc      <= 1'b1;
            huff_addr <= HUFF_CODE_LEN'(sym_idx);
            huff_len  <= len_eff;
            huff_code <= sel_code;
            for (int b = 1; b <= MAX_LEN; b++) begin
              if (len_eff == len_t'(b)) next_code[b] <= next_code[b] + CODE_W'(1);
            end
          end
        end
        CALC: begin
          next_code <= calc_code;
          index     <= '0;
          rd_pend   <= 1'b0;
`ifdef HUFFTREE_OVERSUB_CHK_EN
          oversub   <= calc_over;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_huff_tree_gen.sv
// Directed self-checking bench for huff_tree_gen with a 1-cycle-latency length buffer.
// Optional feature macro: HUFFTREE_OVERSUB_CHK_EN enables the oversub checks.
module tb_huff_tree_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc = 1'b0;
  logic [5:0] tree_num = '0;
  logic [5:0] buff_addr_bias = '0;
  logic [4:0] buff_data;
  logic [8:0] buff_addr;
  logic [4:0] huff_code;
  logic [7:0] huff_addr;
  logic [3:0] huff_len;
  logic       winc;
  logic       finish;
`ifdef HUFFTREE_OVERSUB_CHK_EN
  logic       oversub;
`endif

  always #5 clk = ~clk;

  huff_tree_gen #(.HUFF_CODE_LEN(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inc            (inc),
    .tree_num       (tree_num),
    .buff_data      (buff_data),
    .buff_addr_bias (buff_addr_bias),
    .buff_addr      (buff_addr),
    .huff_code      (huff_code),
    .huff_addr      (huff_addr),
    .huff_len       (huff_len),
    .winc           (winc),
    .finish         (finish)
`ifdef HUFFTREE_OVERSUB_CHK_EN
    ,
    .oversub        (oversub)
`endif
  );

  // Length buffer: data valid the cycle after the address is presented.
  logic [4:0] mem [0:511];
  always @(posedge clk) buff_data <= mem[buff_addr];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_count = 0;
  int fin_count = 0;
  int fin_cyc = 0;
  int start_cyc = 0;
  int order_bad = 0;
  logic [4:0] cap_code [0:63];
  logic [3:0] cap_len  [0:63];
  int exp_code [0:63];
  int exp_len  [0:63];

  int t1_len  [10] = '{3, 3, 3, 4, 3, 2, 0, 4, 0, 3};
  int t1_code [10] = '{2, 3, 4, 14, 5, 0, 0, 15, 0, 6};

  always @(posedge clk) cyc <= cyc + 1;

  // Table-write and done-pulse capture, sampled away from the active edge.
  always @(negedge clk) begin
    if (winc) begin
      if (int'(huff_addr) != wr_count) order_bad++;
      cap_code[huff_addr[5:0]] = huff_code;
      cap_len[huff_addr[5:0]]  = huff_len;
      wr_count++;
    end
    if (finish) begin
      fin_count++;
      fin_cyc = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < 512; i++) mem[i] = '0;
  endtask

  task automatic load10(input int bias);
    clearMem();
    for (int i = 0; i < 10; i++) begin
      mem[bias + i] = 5'(t1_len[i]);
      exp_len[i]    = t1_len[i];
      exp_code[i]   = t1_code[i];
    end
  endtask

  task automatic applyStimulus(input int n, input int bias, input int inj);
    wr_count  = 0;
    fin_count = 0;
    order_bad = 0;
    for (int i = 0; i < 64; i++) begin
      cap_code[i] = 'x;
      cap_len[i]  = 'x;
    end
    @(negedge clk);
    tree_num       = 6'(n);
    buff_addr_bias = 6'(bias);
    inc            = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    inc       = 1'b0;
    for (int t = 1; t < 300 && fin_count == 0; t++) begin
      inc = (t == inj);
      @(negedge clk);
      #1;
    end
    inc = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic checkRun(input string tag, input int n, input int lat);
    checkOutput({tag, "_writes"}, wr_count, n);
    checkOutput({tag, "_finishes"}, fin_count, 1);
    checkOutput({tag, "_latency"}, fin_cyc - start_cyc, lat);
    checkOutput({tag, "_order"}, order_bad, 0);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_sym%0d", tag, i), {23'b0, cap_len[i], cap_code[i]},
                  32'((exp_len[i] << 5) | exp_code[i]));
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_winc"}, winc, 0);
    checkOutput({tag, "_finish"}, finish, 0);
    checkOutput({tag, "_code"}, huff_code, 0);
    checkOutput({tag, "_len"}, huff_len, 0);
    checkOutput({tag, "_haddr"}, huff_addr, 0);
    checkOutput({tag, "_baddr"}, buff_addr, 0);
  endtask

  initial begin
    clearMem();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkIdleOutputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] reference table, bias 0");
    load10(0);
    applyStimulus(10, 0, 0);
    checkRun("t1", 10, 24);

    $display("[TB] reference table, bias 20");
    load10(20);
    applyStimulus(10, 20, 0);
    checkRun("t2", 10, 24);

    $display("[TB] empty tree");
    applyStimulus(0, 0, 0);
    checkOutput("t3_writes", wr_count, 0);
    checkOutput("t3_finishes", fin_count, 1);
    checkOutput("t3_latency", fin_cyc - start_cyc, 1);

    $display("[TB] inc pulsed during ASSIGN");
    load10(0);
    applyStimulus(10, 0, 15);
    checkRun("t4", 10, 24);

    $display("[TB] reset during COUNT");
    wr_count  = 0;
    fin_count = 0;
    @(negedge clk);
    tree_num       = 6'd10;
    buff_addr_bias = 6'd0;
    inc            = 1'b1;
    @(negedge clk);
    inc = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("t5_abort");
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("t5_no_writes", wr_count, 0);
    checkOutput("t5_no_finish", fin_count, 0);
    applyStimulus(10, 0, 0);
    checkRun("t5", 10, 24);

    $display("[TB] out-of-range length treated as unused");
    clearMem();
    mem[0] = 5'd2; mem[1] = 5'd7; mem[2] = 5'd2; mem[3] = 5'd1;
    exp_len[0] = 2; exp_code[0] = 2;
    exp_len[1] = 0; exp_code[1] = 0;
    exp_len[2] = 2; exp_code[2] = 3;
    exp_len[3] = 1; exp_code[3] = 0;
    applyStimulus(4, 0, 0);
    checkRun("t6", 4, 12);

    $display("[TB] complete set 1,2,2");
    clearMem();
    mem[0] = 5'd1; mem[1] = 5'd2; mem[2] = 5'd2;
    exp_len[0] = 1; exp_code[0] = 0;
    exp_len[1] = 2; exp_code[1] = 2;
    exp_len[2] = 2; exp_code[2] = 3;
    applyStimulus(3, 0, 0);
    checkRun("t7", 3, 10);
`ifdef HUFFTREE_OVERSUB_CHK_EN
    checkOutput("t7_oversub", oversub, 0);

    $display("[TB] oversubscribed set 1,1,1");
    clearMem();
    mem[0] = 5'd1; mem[1] = 5'd1; mem[2] = 5'd1;
    applyStimulus(3, 0, 0);
    checkOutput("t8_writes", wr_count, 3);
    checkOutput("t8_oversub", oversub, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
